// File: rtl/imm_gen_stream.sv
// imm_gen_stream: RISC-V immediate decoder feeding a DEPTH-entry output FIFO
module imm_gen_stream #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [XLEN-1:0] mem_imm [DEPTH];
    logic [2:0]      mem_fmt [DEPTH];
    logic            mem_ill [DEPTH];
    logic [PW-1:0]   wp, rp;
    logic [CW-1:0]   count;
    logic [31:0]     i;
    logic [31:0]     imm32;
    logic [63:0]     imm64;
    logic [2:0]      fmt;
    logic            push, pop;
    assign i         = in_instr;
    assign in_ready  = count < CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    always_comb begin
        imm32 = '0;
        fmt   = 3'd7;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                imm32 = {{20{i[31]}}, i[31:20]};
                fmt   = 3'd1;
            end
            7'b0100011: begin
                imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
                fmt   = 3'd2;
            end
            7'b1100011: begin
                imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                fmt   = 3'd3;
            end
            7'b0110111, 7'b0010111: begin
                imm32 = {i[31:12], 12'b0};
                fmt   = 3'd4;
            end
            7'b1101111: begin
                imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                fmt   = 3'd5;
            end
            7'b0110011: fmt = 3'd0;
            default: ;
        endcase
        imm64 = {{32{imm32[31]}}, imm32};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_imm[wp] <= imm64[XLEN-1:0];
            mem_fmt[wp] <= fmt;
            mem_ill[wp] <= fmt == 3'd7;
        end
    end
    assign out_imm     = out_valid ? mem_imm[rp] : '0;
    assign out_fmt     = out_valid ? mem_fmt[rp] : '0;
    assign out_illegal = out_valid ? mem_ill[rp] : 1'b0;
endmodule

// File: tb/tb_imm_gen_stream.sv
// tb_imm_gen_stream: directed checks of decode, FIFO ordering, backpressure and reset
module tb_imm_gen_stream;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    int          errors = 0;
    int          checks = 0;

    imm_gen_stream #(.XLEN(64), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".imm"}, out_imm, imm);
        chk({tag, ".fmt"}, 64'(out_fmt), 64'(fmt));
        chk({tag, ".ill"}, 64'(out_illegal), 64'(ill));
    endtask

    task automatic empty(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".ready"}, 64'(in_ready), 64'd1);
        chk({tag, ".imm"}, out_imm, 64'd0);
        chk({tag, ".fmt"}, 64'(out_fmt), 64'd0);
        chk({tag, ".ill"}, 64'(out_illegal), 64'd0);
    endtask

    task automatic single(input string tag, input logic [31:0] instr, input logic [63:0] imm,
                          input logic [2:0] fmt, input logic ill);
        in_valid  = 1'b1;
        in_instr  = instr;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        head(tag, imm, fmt, ill);
        step();
        chk({tag, ".drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFC12083;
        out_ready = 1'b0;
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        empty("reset");

        single("lw", 32'hFFC12083, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0);
        single("addi", 32'h7FF00093, 64'h00000000000007FF, 3'd1, 1'b0);
        single("lui", 32'h123450B7, 64'h0000000012345000, 3'd4, 1'b0);
        single("lui_neg", 32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
        single("jal", 32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);
        single("illegal", 32'h0000007F, 64'd0, 3'd7, 1'b1);
        single("rtype", 32'h00000033, 64'd0, 3'd0, 1'b0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFE512C23;
        step();
        in_instr = 32'hFE000EE3;
        step();
        in_valid = 1'b0;
        head("sw", 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);
        out_ready = 1'b1;
        step();
        head("beq", 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        step();
        empty("sb_drain");

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFC12083;
        step();
        chk("bp.ready1", 64'(in_ready), 64'd1);
        in_instr = 32'h123450B7;
        step();
        chk("bp.full", 64'(in_ready), 64'd0);
        in_instr = 32'h0000007F;
        step();
        chk("bp.held", 64'(in_ready), 64'd0);
        head("bp.stall1", 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0);
        step();
        head("bp.stall2", 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0);
        out_ready = 1'b1;
        step();
        head("bp.second", 64'h0000000012345000, 3'd4, 1'b0);
        chk("bp.ready2", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        head("bp.third", 64'd0, 3'd7, 1'b1);
        step();
        empty("bp_drain");

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFE512C23;
        step();
        in_instr = 32'hFE000EE3;
        step();
        chk("mid.full", 64'(in_ready), 64'd0);
        reset    = 1'b1;
        in_instr = 32'h123450B7;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        empty("mid_reset");
        out_ready = 1'b1;
        step();
        empty("mid_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
